thermal_tx_scheduler: RTL

Transmit-side sequencer for the temporal thermal covert channel. It accepts one byte per frame over a valid/ready handshake and schedules the ring-oscillator heater bank on and off (on-off keying) for a fixed number of cycles per bit. Each frame is preamble, then data, then parity, then a mandatory cool-down guard interval. It sits between the message source and the heater enable of the oscillator array; the receive-side counter and LED display are untouched.

---
 rtl/thermal_cc_pkg.sv | 36 +++
 rtl/thermal_tx_scheduler_if.sv | 11 +
 rtl/thermal_bit_timer.sv | 35 +++
 rtl/thermal_tx_scheduler.sv | 94 +++++++++
 4 files changed

// File: rtl/thermal_cc_pkg.sv
// Shared definitions for the thermal covert channel (transmit scheduler and receive decoder).
package thermal_cc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_DATA  = 2'd2,
        ST_GUARD = 2'd3
    } state_e;

    localparam logic [7:0]  PREAMBLE   = 8'hA5;
    localparam int unsigned PRE_BITS   = 8;
    localparam int unsigned FRAME_BITS = 17;

    localparam logic [1:0] DBG_IDLE  = 2'd0;
    localparam logic [1:0] DBG_PRE   = 2'd1;
    localparam logic [1:0] DBG_DATA  = 2'd2;
    localparam logic [1:0] DBG_GUARD = 2'd3;

    typedef logic [FRAME_BITS-1:0] frame_t;

    // Full on-air frame, MSB transmitted first: preamble, data, even parity.
    function automatic frame_t build_frame(input logic [7:0] data);
        return {PREAMBLE, data, ^data};
    endfunction

    function automatic logic [1:0] state_dbg_of(input state_e s);
        case (s)
            ST_PRE:   return DBG_PRE;
            ST_DATA:  return DBG_DATA;
            ST_GUARD: return DBG_GUARD;
            default:  return DBG_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/thermal_tx_scheduler_if.sv
// Byte handshake between the message source (master) and the scheduler (slave).
interface thermal_tx_scheduler_if;
    // A byte transfers on a rising edge where tx_valid and tx_ready are both high;
    // tx_data must be stable whenever tx_valid is high.
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/thermal_bit_timer.sv
// Bit-period timer: marks the first and last cycle of every BIT_CYCLES-long bit.
module thermal_bit_timer #(
    parameter int unsigned BIT_CYCLES = 2**24
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic bit_strobe,
    output logic bit_end
);

    localparam int unsigned CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          run;

    // clear wins over start so an abort never leaves a bit half-started.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign bit_strobe = run && (cnt == '0);
    assign bit_end    = run && (cnt == LAST);

endmodule

// File: rtl/thermal_tx_scheduler.sv
// On-off-keyed heater sequencer: preamble, data, parity, then a heater-off guard interval.
module thermal_tx_scheduler
    import thermal_cc_pkg::*;
#(
    parameter int unsigned BIT_CYCLES   = 2**24,
    parameter int unsigned GUARD_CYCLES = 2**25
) (
    input  logic                   clk,
    input  logic                   rst,
    thermal_tx_scheduler_if.slave  tx,
    input  logic                   abort,
    output logic                   heat_en,
    output logic                   bit_strobe,
    output logic                   frame_done,
    output logic                   busy,
    output logic [1:0]             state_dbg
);

    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    state_e        state, state_next;
    frame_t        frame_sr;
    logic [4:0]    bit_idx;
    logic [GW-1:0] guard_cnt;
    logic          ready_q;
    logic          done_q;
    logic          bit_end;
    logic          accept, in_frame, abort_hit, pre_last, frame_last, guard_last;

    assign accept     = tx.tx_valid && tx.tx_ready;
    assign in_frame   = (state == ST_PRE) || (state == ST_DATA);
    assign abort_hit  = abort && in_frame;
    assign pre_last   = bit_end && (bit_idx == 5'(PRE_BITS - 1));
    assign frame_last = bit_end && (bit_idx == 5'(FRAME_BITS - 1));
    assign guard_last = (guard_cnt == GUARD_LAST);

    thermal_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .start      (accept),
        .clear      (abort_hit || frame_last),
        .bit_strobe (bit_strobe),
        .bit_end    (bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_PRE;
            ST_PRE:   if (abort) state_next = ST_GUARD;
                      else if (pre_last) state_next = ST_DATA;
            ST_DATA:  if (abort || frame_last) state_next = ST_GUARD;
            ST_GUARD: if (guard_last) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        heat_en     = in_frame && frame_sr[FRAME_BITS-1];
        busy        = (state != ST_IDLE);
        state_dbg   = state_dbg_of(state);
        tx.tx_ready = ready_q && (state == ST_IDLE);
        frame_done  = done_q;
    end

    // ready_q keeps tx_ready low until the first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_sr  <= '0;
            bit_idx   <= '0;
            guard_cnt <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            done_q  <= (state == ST_GUARD) && guard_last;
            if (accept) begin
                frame_sr <= build_frame(tx.tx_data);
                bit_idx  <= '0;
            end else if (bit_end && !abort_hit) begin
                frame_sr <= {frame_sr[FRAME_BITS-2:0], 1'b0};
                bit_idx  <= bit_idx + 5'd1;
            end
            guard_cnt <= (state == ST_GUARD) ? guard_cnt + GW'(1) : '0;
        end
    end

endmodule
